// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub
//  Purpose  : Bit-serial two's-complement subtractor, Diff = x - y - b,
//             processed one bit per clock, LSB first, with start/busy/done
//             handshake, borrow-out and signed-overflow flags.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start             - request, accepted only when not busy
//             x, y, b           - minuend, subtrahend, borrow-in (latched)
//             busy              - high while bits are being processed
//             done              - one-cycle pulse, result valid
//             Diff, Borrow, Over- difference, borrow out of MSB, overflow
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Borrow,
    output logic         Over
);

    localparam int              c_KW     = $clog2(N);
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [N-1:0]      r_x;
    logic [N-1:0]      r_y;
    logic              r_br;
    logic [c_KW-1:0]   r_k;
    logic [N-1:0]      r_diff;
    logic              r_borrow;
    logic              r_over;

    logic              w_accept;
    logic              w_last;
    logic              w_d;
    logic              w_br_nxt;

    // A start in RUN is ignored; IDLE and DONE both accept.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_k == c_K_LAST);

    // Full-subtractor on the current LSBs of the shifting operands.
    assign w_d      = r_x[0] ^ r_y[0] ^ r_br;
    assign w_br_nxt = (~r_x[0] & r_y[0]) | (~r_x[0] & r_br) | (r_y[0] & r_br);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_k == c_K_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, borrow flop, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_br     <= 1'b0;
            r_k      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_over   <= 1'b0;
        end else if (w_accept) begin
            r_x  <= x;
            r_y  <= y;
            r_br <= b;
            r_k  <= '0;
        end else if (r_state == S_RUN) begin
            r_x    <= r_x >> 1;
            r_y    <= r_y >> 1;
            r_br   <= w_br_nxt;
            r_k    <= r_k + 1'b1;
            // Result enters at the MSB and moves down; after N shifts the
            // first computed bit sits at bit 0.
            r_diff <= {w_d, r_diff[N-1:1]};
            if (w_last) begin
                r_borrow <= w_br_nxt;
                // On the last bit r_br is still the borrow into the MSB.
                r_over   <= r_br ^ w_br_nxt;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign Diff   = r_diff;
    assign Borrow = r_borrow;
    assign Over   = r_over;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub
//  Purpose  : Self-checking bench for serial_sub (N = 4): table of directed
//             vectors, random operations against a reference model, a
//             back-to-back throughput sequence and a mid-run reset abort.
//             Expected results travel through a scoreboard queue and are
//             compared when the DUT raises done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         b;
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         Borrow;
    logic         Over;

    int errors = 0;
    int checks = 0;

    // {Diff, Borrow, Over}
    logic [5:0] sb[$];

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       b;
        logic [3:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t tbl[8];

    serial_sub #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Borrow(Borrow),
        .Over  (Over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: integer arithmetic, independent of the bit-serial form.
    function automatic logic [5:0] model(input logic [3:0] xa, input logic [3:0] ya, input logic ba);
        int u;
        int sx;
        int sy;
        int s;
        logic [3:0] d;
        u  = int'(xa) - int'(ya) - int'(ba);
        sx = xa[3] ? int'(xa) - 16 : int'(xa);
        sy = ya[3] ? int'(ya) - 16 : int'(ya);
        s  = sx - sy - int'(ba);
        d  = 4'(u);
        return {d, (u < 0), (s < -8 || s > 7)};
    endfunction

    // Monitor: handshake sanity every cycle, scoreboard compare on done.
    logic       prev_done = 1'b0;
    logic [5:0] exp_r;
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            checks++;
            if ((busy && done) || (done && prev_done)) begin
                errors++;
                $display("FAIL handshake: busy=%b done=%b prev_done=%b required busy&done=0 and single-cycle done",
                         busy, done, prev_done);
            end
            prev_done = done;
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done seen with empty scoreboard, Diff=%h", Diff);
                end else begin
                    exp_r = sb.pop_front();
                    if ({Diff, Borrow, Over} !== exp_r) begin
                        errors++;
                        $display("FAIL result: Diff=%h Borrow=%b Over=%b required Diff=%h Borrow=%b Over=%b",
                                 Diff, Borrow, Over, exp_r[5:2], exp_r[1], exp_r[0]);
                    end
                end
            end
        end
    end

    // One operation with latency and hold checks; operands and start are
    // disturbed while RUN to confirm they are ignored.
    task automatic run_op(input logic [3:0] xa, input logic [3:0] ya, input logic ba, input logic [5:0] e);
        int lat;
        bit seen;
        @(negedge clk);
        x = xa; y = ya; b = ba; start = 1'b1;
        sb.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 2) begin
                x = 4'($urandom); y = 4'($urandom); b = 1'($urandom); start = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        checks++;
        if (!seen || lat != N + 1) begin
            errors++;
            $display("FAIL latency: seen=%0d cycles=%0d required %0d", seen, lat, N + 1);
        end
        @(negedge clk);
        checks++;
        if ({Diff, Borrow, Over} !== e) begin
            errors++;
            $display("FAIL hold: Diff=%h Borrow=%b Over=%b required Diff=%h Borrow=%b Over=%b",
                     Diff, Borrow, Over, e[5:2], e[1], e[0]);
        end
    endtask

    initial begin
        int nbusy;
        int dmask;
        int ndone;
        logic [3:0] rx;
        logic [3:0] ry;
        logic       rb;

        tbl[0] = '{4'd5,  4'd3,  1'b0, 4'h2, 1'b0, 1'b0};
        tbl[1] = '{4'd3,  4'd5,  1'b0, 4'hE, 1'b1, 1'b0};
        tbl[2] = '{4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1};
        tbl[3] = '{4'd7,  4'd15, 1'b0, 4'h8, 1'b1, 1'b1};
        tbl[4] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        tbl[5] = '{4'd9,  4'd9,  1'b1, 4'hF, 1'b1, 1'b0};
        tbl[6] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0};
        tbl[7] = '{4'd0,  4'd8,  1'b0, 4'h8, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; x = '0; y = '0; b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, Diff, Borrow, Over} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b Diff=%h Borrow=%b Over=%b required all 0",
                     busy, done, Diff, Borrow, Over);
        end
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].b, {tbl[i].d, tbl[i].br, tbl[i].ov});
        end

        // Random operations against the model
        for (int i = 0; i < 6; i++) begin
            rx = 4'($urandom); ry = 4'($urandom); rb = 1'($urandom);
            run_op(rx, ry, rb, model(rx, ry, rb));
        end

        // Back-to-back: start held high for three operations
        @(negedge clk);
        x = 4'd5; y = 4'd3; b = 1'b0; start = 1'b1;
        sb.push_back(model(4'd5, 4'd3, 1'b0));
        nbusy = 0;
        dmask = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) dmask = dmask | (1 << i);
            if (i == 2 || i == 7 || i == 12) begin
                x = 4'hA; y = 4'h6; b = 1'b1;
            end
            if (i == 5) begin
                x = 4'd3; y = 4'd5; b = 1'b0;
                sb.push_back(model(4'd3, 4'd5, 1'b0));
            end
            if (i == 10) begin
                x = 4'd8; y = 4'd1; b = 1'b0;
                sb.push_back(model(4'd8, 4'd1, 1'b0));
            end
            if (i == 11) start = 1'b0;
        end
        checks++;
        if (nbusy != 12) begin
            errors++;
            $display("FAIL throughput_busy: busy cycles=%0d required 12", nbusy);
        end
        checks++;
        if (dmask != ((1 << 5) | (1 << 10) | (1 << 15))) begin
            errors++;
            $display("FAIL throughput_done: done mask=%h required %h", dmask, (1 << 5) | (1 << 10) | (1 << 15));
        end
        repeat (2) @(negedge clk);

        // Reset at the second RUN edge aborts the operation
        x = 4'd6; y = 4'd1; b = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, Diff, Borrow, Over} !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b Diff=%h Borrow=%b Over=%b required all 0",
                     busy, done, Diff, Borrow, Over);
        end
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", ndone);
        end
        run_op(4'd6, 4'd1, 1'b0, {4'h5, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
